output_bank: RTL and testbench

Parametrised memory-mapped output peripheral: successor to the single 8-bit LED register. Provides `NUM_CHANNELS` output channels of `CH_WIDTH` bits with byte/half/word write lanes and per-channel PWM dimming. Duty updates are double-buffered so they never glitch mid-period. Sits on the core's output bus (`output_*` signals) and drives board LEDs or GPIO pins.

---
 rtl/output_bank.sv | 143 ++++++++++++++
 tb/tb_output_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_bank.sv
// rtl/output_bank.sv - memory-mapped output bank with byte/half/word lane writes and per-channel PWM dimming
// Duty changes go through a per-channel shadow that reloads only at period end, so the PWM waveform never glitches.
module output_bank #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_WIDTH     = 8,
  parameter int PWM_BITS     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [31:0]                      output_address,
  input  logic [31:0]                      output_in,
  input  logic [1:0]                       output_size,
  input  logic                             output_write_enable,
  output logic [31:0]                      output_out,
  output logic [NUM_CHANNELS*CH_WIDTH-1:0] led
);

  localparam int DUTY_W = PWM_BITS + 1;

  logic [CH_WIDTH-1:0]     data_q     [NUM_CHANNELS];
  logic [DUTY_W-1:0]       duty_q     [NUM_CHANNELS];
  logic [DUTY_W-1:0]       act_duty_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mode_q;
  logic [15:0]             prescale_q;
  logic [15:0]             prescale_cnt;
  logic [PWM_BITS-1:0]     pwm_cnt;

  logic [1:0] region;
  logic [3:0] ch_idx;
  logic [5:0] word_idx;
  logic       is_mode;
  logic       is_prescale;
  logic       is_status;

  assign region      = output_address[7:6];
  assign ch_idx      = output_address[5:2];
  assign word_idx    = output_address[7:2];
  assign is_mode     = (word_idx == 6'h20);
  assign is_prescale = (word_idx == 6'h21);
  assign is_status   = (word_idx == 6'h22);

  // Read mux: one word per address, unmapped space reads zero.
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (region == 2'd0 && ch_idx == 4'(i)) rd_word = 32'(data_q[i]);
      if (region == 2'd1 && ch_idx == 4'(i)) rd_word = 32'(duty_q[i]);
    end
    if (is_mode)     rd_word = 32'(mode_q);
    if (is_prescale) rd_word = 32'(prescale_q);
    if (is_status)   rd_word = {prescale_cnt, 16'(pwm_cnt)};
  end

  assign output_out = rd_word;

  // Lane merge: sub-word writes overlay the addressed lane onto the current register word.
  logic [31:0] wr_word;
  logic        size_ok;
  logic        wr_en;

  always_comb begin
    wr_word = rd_word;
    size_ok = 1'b0;
    case (output_size)
      2'd0: begin
        size_ok = 1'b1;
        case (output_address[1:0])
          2'd0:    wr_word[7:0]   = output_in[7:0];
          2'd1:    wr_word[15:8]  = output_in[7:0];
          2'd2:    wr_word[23:16] = output_in[7:0];
          default: wr_word[31:24] = output_in[7:0];
        endcase
      end
      2'd1: begin
        size_ok = ~output_address[0];
        if (output_address[1]) wr_word[31:16] = output_in[15:0];
        else                   wr_word[15:0]  = output_in[15:0];
      end
      2'd2: begin
        size_ok = (output_address[1:0] == 2'b00);
        wr_word = output_in;
      end
      default: size_ok = 1'b0;
    endcase
  end

  assign wr_en = output_write_enable & size_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        data_q[i] <= '0;
        duty_q[i] <= '0;
      end
      mode_q     <= '0;
      prescale_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (region == 2'd0 && ch_idx == 4'(i)) data_q[i] <= wr_word[CH_WIDTH-1:0];
        if (region == 2'd1 && ch_idx == 4'(i)) duty_q[i] <= wr_word[DUTY_W-1:0];
      end
      if (is_mode)     mode_q     <= wr_word[NUM_CHANNELS-1:0];
      if (is_prescale) prescale_q <= wr_word[15:0];
    end
  end

  // The >= compare lets the counter recover when PRESCALE is lowered below it.
  logic tick;
  logic period_end;

  assign tick       = (prescale_cnt >= prescale_q);
  assign period_end = tick && (pwm_cnt == '1);

  logic [NUM_CHANNELS*CH_WIDTH-1:0] led_next;

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (mode_q[i] && !({1'b0, pwm_cnt} < act_duty_q[i])) led_next[i*CH_WIDTH +: CH_WIDTH] = '0;
      else led_next[i*CH_WIDTH +: CH_WIDTH] = data_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_cnt <= '0;
      pwm_cnt      <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) act_duty_q[i] <= '0;
      led          <= '0;
    end else begin
      prescale_cnt <= tick ? 16'd0 : prescale_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      // Shadow tracks DUTY freely while PWM is off, so enabling PWM starts from the current duty.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (period_end || !mode_q[i]) act_duty_q[i] <= duty_q[i];
      end
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_output_bank.sv
// tb/tb_output_bank.sv - randomized scoreboard bench for output_bank against a behavioural model
module tb_output_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PB  = 8;
  localparam int PERIOD_STEPS = 1 << PB;

  logic        clk;
  logic        rst_n;
  logic [31:0] output_address;
  logic [31:0] output_in;
  logic [1:0]  output_size;
  logic        output_write_enable;
  logic [31:0] output_out;
  logic [NCH*CW-1:0] led;

  output_bank #(.NUM_CHANNELS(NCH), .CH_WIDTH(CW), .PWM_BITS(PB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .output_address(output_address),
    .output_in(output_in),
    .output_size(output_size),
    .output_write_enable(output_write_enable),
    .output_out(output_out),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] led;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Behavioural model: plain integers following the register-map and PWM rules.
  int m_data[NCH];
  int m_duty[NCH];
  int m_shadow[NCH];
  int m_led[NCH];
  int m_mode, m_presc, m_pcnt, m_wcnt;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_data[i] = 0; m_duty[i] = 0; m_shadow[i] = 0; m_led[i] = 0;
    end
    m_mode = 0; m_presc = 0; m_pcnt = 0; m_wcnt = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int a;
    a = int'(addr & 32'hFC);
    if (a < 'h40) return (a / 4 < NCH) ? 32'(m_data[a / 4]) : 32'd0;
    if (a < 'h80) return ((a - 'h40) / 4 < NCH) ? 32'(m_duty[(a - 'h40) / 4]) : 32'd0;
    if (a == 'h80) return 32'(m_mode);
    if (a == 'h84) return 32'(m_presc);
    if (a == 'h88) return 32'(m_pcnt * 65536 + m_wcnt);
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_led();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*CW +: CW] = m_led[i][CW-1:0];
    return v;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] din);
    logic [31:0] w;
    int lo, a, src;
    bit ok, sel;
    w  = model_read(addr);
    lo = int'(addr & 32'h3);
    case (size)
      2'd0: ok = 1;
      2'd1: ok = (lo % 2 == 0);
      2'd2: ok = (lo == 0);
      default: ok = 0;
    endcase
    if (!ok) return;
    for (int b = 0; b < 4; b++) begin
      sel = (size == 2) || (size == 1 && b / 2 == lo / 2) || (size == 0 && b == lo);
      src = (size == 2) ? b : (size == 1) ? b % 2 : 0;
      if (sel) w[8*b +: 8] = din[8*src +: 8];
    end
    a = int'(addr & 32'hFC);
    if (a < 'h40 && a / 4 < NCH) m_data[a / 4] = int'(w) & ((1 << CW) - 1);
    else if (a >= 'h40 && a < 'h80 && (a - 'h40) / 4 < NCH) m_duty[(a - 'h40) / 4] = int'(w) & ((1 << (PB + 1)) - 1);
    else if (a == 'h80) m_mode = int'(w) & ((1 << NCH) - 1);
    else if (a == 'h84) m_presc = int'(w) & 'hFFFF;
  endtask

  task automatic model_step(input bit we, input logic [31:0] addr, input logic [1:0] size, input logic [31:0] din);
    bit tick, pend, en;
    tick = (m_pcnt >= m_presc);
    pend = tick && (m_wcnt == PERIOD_STEPS - 1);
    for (int i = 0; i < NCH; i++) begin
      en = m_mode[i];
      m_led[i] = (en && !(m_wcnt < m_shadow[i])) ? 0 : m_data[i];
    end
    for (int i = 0; i < NCH; i++) begin
      if (pend || !m_mode[i]) m_shadow[i] = m_duty[i];
    end
    m_pcnt = tick ? 0 : (m_pcnt + 1) & 'hFFFF;
    if (tick) m_wcnt = (m_wcnt + 1) % PERIOD_STEPS;
    if (we) model_write(addr, size, din);
  endtask

  task automatic push_exp(input logic [31:0] addr);
    exp_t e;
    e.led = model_led();
    e.rd  = model_read(addr);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit we, input logic [31:0] addr, input logic [1:0] size, input logic [31:0] din);
    @(negedge clk);
    output_write_enable = we;
    output_address      = addr;
    output_size         = size;
    output_in           = din;
    push_exp(addr);
    model_step(we, addr, size, din);
  endtask

  task automatic idle(input int n, input logic [31:0] addr);
    for (int k = 0; k < n; k++) cyc(1'b0, addr, 2'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] din);
    cyc(1'b1, addr, 2'd2, din);
  endtask

  // Reset asserted between edges; led must clear before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    output_write_enable = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    push_exp(output_address);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic timeout_fail(input string what);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired (wcnt=%0d pcnt=%0d)", what, m_wcnt, m_pcnt);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (led !== e.led) begin
          n_bad++;
          $display("FAIL led @%0t: got %h expected %h", $time, led, e.led);
        end
        n_vec++;
        if (output_out !== e.rd) begin
          n_bad++;
          $display("FAIL output_out addr=%h @%0t: got %h expected %h", output_address, $time, output_out, e.rd);
        end
      end
    end
  end

  initial begin
    int k;
    logic [31:0] a, d;
    logic [1:0]  s;
    int pick;

    rst_n = 1'b0;
    output_address = '0;
    output_in = '0;
    output_size = '0;
    output_write_enable = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int r = 0; r <= 'h88; r += 4) idle(1, 32'(r));

    wr(32'h00, 32'h000000A5);
    idle(2, 32'h00);
    cyc(1'b1, 32'h05, 2'd0, 32'h3C);
    idle(1, 32'h04);
    cyc(1'b1, 32'h04, 2'd0, 32'h5A);
    cyc(1'b1, 32'h41, 2'd1, 32'h1234);
    idle(1, 32'h40);
    cyc(1'b1, 32'h42, 2'd1, 32'hBEEF);
    idle(1, 32'h40);
    cyc(1'b1, 32'h4A, 2'd2, 32'h55);
    wr(32'hC0, 32'hFFFFFFFF);
    idle(1, 32'hC0);

    wr(32'h08, 32'hFF);
    wr(32'h48, 32'd64);
    wr(32'h84, 32'd0);
    wr(32'h80, 32'h4);
    idle(600, 32'h88);
    wr(32'h48, 32'd0);
    idle(600, 32'h88);
    wr(32'h48, 32'd256);
    idle(600, 32'h48);

    wr(32'h48, 32'd64);
    idle(300, 32'h88);
    for (k = 0; k < 1000 && m_wcnt != 100; k++) idle(1, 32'h88);
    if (m_wcnt != 100) timeout_fail("wait_pwm_100");
    wr(32'h48, 32'd200);
    idle(600, 32'h88);
    for (k = 0; k < 1000 && !(m_wcnt == PERIOD_STEPS - 1 && m_pcnt >= m_presc); k++) idle(1, 32'h88);
    if (!(m_wcnt == PERIOD_STEPS - 1)) timeout_fail("wait_period_end");
    wr(32'h48, 32'd30);
    idle(600, 32'h88);

    wr(32'h40, 32'd2);
    wr(32'h84, 32'd3);
    wr(32'h80, 32'h5);
    idle(1100, 32'h88);
    for (k = 0; k < 10 && m_pcnt != 2; k++) idle(1, 32'h88);
    if (m_pcnt != 2) timeout_fail("wait_prescale_2");
    wr(32'h84, 32'd1);
    idle(100, 32'h88);

    wr(32'h84, 32'd0);
    wr(32'h0C, 32'h77);
    for (k = 0; k < 1000 && m_wcnt != 150; k++) idle(1, 32'h88);
    if (m_wcnt != 150) timeout_fail("wait_pwm_150");
    do_reset();
    idle(300, 32'h88);
    for (int r = 0; r <= 'h88; r += 4) idle(1, 32'(r));

    for (int n = 0; n < 3000; n++) begin
      pick = $urandom_range(0, 11);
      if (pick < 4)       a = 32'(pick * 4);
      else if (pick < 8)  a = 32'('h40 + (pick - 4) * 4);
      else if (pick == 8) a = 32'h80;
      else if (pick == 9) a = 32'h84;
      else if (pick == 10) a = 32'h88;
      else a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'($urandom_range(0, 3));
      a[31:8] = 24'($urandom);
      s = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a[7:6] == 2'd1) d = 32'($urandom_range(0, 300));
      if (a[7:2] == 6'h21) begin
        a[1:0] = 2'b00;
        s = 2'd2;
        d = 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc($urandom_range(0, 9) < 3, a, s, d);
    end

    idle(2, 32'h88);
    repeat (3) @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
